// File: rtl/tr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tr_pkg : state/zone types and zone-to-period mapping for tr_step_regulator
// Rev 1.0
// ----------------------------------------------------------------------------
package tr_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    HOLD     = 2'd1,
    TRACK    = 2'd2,
    DIR_WAIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    Z_NONE   = 2'd0,
    Z_FINE   = 2'd1,
    Z_MID    = 2'd2,
    Z_COARSE = 2'd3
  } zone_t;

  // A zone of NONE never reaches the step generator while tracking, so 0 is a safe filler.
  function automatic int zone_period(zone_t z, int p_coarse, int p_mid, int p_fine);
    int p;
    case (z)
      Z_COARSE: p = p_coarse;
      Z_MID:    p = p_mid;
      Z_FINE:   p = p_fine;
      default:  p = 0;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tr_step_regulator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tr_step_regulator_if : ADC sample input and step/dir driver pins
// Rev 1.0
// ----------------------------------------------------------------------------
interface tr_step_regulator_if #(
  parameter int WIDTH_IN = 12
);
  logic                data_valid;
  logic [WIDTH_IN-1:0] x;
  logic [WIDTH_IN-1:0] x0;
  logic [WIDTH_IN-1:0] dx1;
  logic [WIDTH_IN-1:0] dx2;
  logic                drv_step;
  logic                drv_dir;
  logic                drv_SM;

  modport master (
    output data_valid, x, x0, dx1, dx2,
    input  drv_step, drv_dir, drv_SM
  );

  modport slave (
    input  data_valid, x, x0, dx1, dx2,
    output drv_step, drv_dir, drv_SM
  );
endinterface
`default_nettype wire

// File: rtl/tr_step_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tr_step_gen : step period counter and fixed-width, never-truncated pulse timer
// Rev 1.0
// ----------------------------------------------------------------------------
module tr_step_gen #(
  parameter int WIDTH_WORK = 17,
  parameter int PULSE_W    = 50
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  run,
  input  wire logic [WIDTH_WORK-1:0] period,
  output logic                       start,
  output logic                       drv_step
);

  localparam logic [WIDTH_WORK-1:0] c_PW_LOAD = WIDTH_WORK'(PULSE_W - 1);
  localparam logic [WIDTH_WORK-1:0] c_ONE     = WIDTH_WORK'(1);

  logic [WIDTH_WORK-1:0] r_period_cnt;
  logic [WIDTH_WORK-1:0] r_pulse_cnt;

  // The start cycle is itself the first high cycle, so a pulse begins on TRACK entry.
  assign start    = run && (r_period_cnt == '0) && (r_pulse_cnt == '0);
  assign drv_step = start || (r_pulse_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_pulse_cnt  <= '0;
    end else begin
      if (start) begin
        r_pulse_cnt <= c_PW_LOAD;
      end else if (r_pulse_cnt != '0) begin
        r_pulse_cnt <= r_pulse_cnt - c_ONE;
      end

      if (!run) begin
        r_period_cnt <= '0;
      end else if (start) begin
        r_period_cnt <= (period == '0) ? '0 : period - c_ONE;
      end else if (r_period_cnt != '0) begin
        r_period_cnt <= r_period_cnt - c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tr_step_regulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tr_step_regulator : closed-loop step/dir regulator with speed zones and dead zone
// Rev 1.0
// ----------------------------------------------------------------------------
module tr_step_regulator
  import tr_pkg::*;
#(
  parameter int WIDTH_IN   = 12,
  parameter int WIDTH_WORK = 17,
  parameter int DEADZONE   = 19,
  parameter int CONST      = 0,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETUP  = 250,
  parameter int P_COARSE   = 800,
  parameter int P_MID      = 39600,
  parameter int P_FINE     = 80000
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  enable,
  tr_step_regulator_if.slave         bus,
  output logic [WIDTH_WORK-1:0]      step_cnt,
  output logic [1:0]                 zone,
  output logic                       in_hold
);

  if (PULSE_W >= P_COARSE) begin : g_chk_pulse
    $error("PULSE_W must be smaller than P_COARSE");
  end
  if (CONST >= DEADZONE) begin : g_chk_hyst
    $error("CONST must be smaller than DEADZONE");
  end
  if (P_FINE >= (1 << WIDTH_WORK)) begin : g_chk_width
    $error("P_FINE does not fit in WIDTH_WORK bits");
  end
  if (DIR_SETUP < 1) begin : g_chk_setup
    $error("DIR_SETUP must be at least 1");
  end

  localparam logic [WIDTH_IN-1:0]   c_DEADZONE   = WIDTH_IN'(DEADZONE);
  localparam logic [WIDTH_IN-1:0]   c_CONST      = WIDTH_IN'(CONST);
  localparam logic [WIDTH_WORK-1:0] c_SETUP_LOAD = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] c_ONE        = WIDTH_WORK'(1);

  logic [WIDTH_IN-1:0]   r_x, r_x0, r_dx1, r_dx2;
  logic [WIDTH_IN-1:0]   r_absdx;
  logic                  r_sign;
  zone_t                 r_zone;
  logic                  w_lt;
  logic [WIDTH_IN-1:0]   w_absdx;
  zone_t                 w_zone;
  logic [WIDTH_WORK-1:0] w_period;
  logic                  w_run;
  logic                  w_start;
  logic                  w_step;

  state_t                r_state;
  logic                  r_dir;
  logic                  r_sm;
  logic                  r_in_hold;
  logic                  r_dir_done;
  logic [WIDTH_WORK-1:0] r_setup_cnt;
  logic [WIDTH_WORK-1:0] r_step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_x0  <= '0;
      r_dx1 <= '0;
      r_dx2 <= '0;
    end else if (bus.data_valid) begin
      r_x   <= bus.x;
      r_x0  <= bus.x0;
      r_dx1 <= bus.dx1;
      r_dx2 <= bus.dx2;
    end
  end

  assign w_lt    = (r_x < r_x0);
  assign w_absdx = w_lt ? (r_x0 - r_x) : (r_x - r_x0);

  // Coarse is tested first, so an inverted dx1/dx2 pair still resolves deterministically.
  always_comb begin
    w_zone = Z_NONE;
    if (w_absdx >= r_dx2) begin
      w_zone = Z_COARSE;
    end else if (w_absdx >= r_dx1) begin
      w_zone = Z_MID;
    end else if (w_absdx != '0) begin
      w_zone = Z_FINE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_absdx <= '0;
      r_sign  <= 1'b0;
      r_zone  <= Z_NONE;
    end else begin
      r_absdx <= w_absdx;
      r_sign  <= w_lt;
      r_zone  <= w_zone;
    end
  end

  assign w_period = WIDTH_WORK'(zone_period(r_zone, P_COARSE, P_MID, P_FINE));
  assign w_run    = (r_state == TRACK);

  tr_step_gen #(
    .WIDTH_WORK (WIDTH_WORK),
    .PULSE_W    (PULSE_W)
  ) u_step_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .period   (w_period),
    .start    (w_start),
    .drv_step (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OFF;
      r_dir       <= 1'b0;
      r_sm        <= 1'b0;
      r_in_hold   <= 1'b0;
      r_dir_done  <= 1'b0;
      r_setup_cnt <= '0;
    end else if (!enable) begin
      r_state   <= OFF;
      r_sm      <= 1'b0;
      r_in_hold <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          r_state   <= HOLD;
          r_sm      <= 1'b1;
          r_in_hold <= 1'b1;
        end
        HOLD: begin
          if (r_absdx > c_DEADZONE) begin
            r_in_hold  <= 1'b0;
            r_dir_done <= 1'b0;
            r_state    <= (r_sign == r_dir) ? TRACK : DIR_WAIT;
          end
        end
        TRACK: begin
          if (r_absdx <= c_CONST) begin
            r_state   <= HOLD;
            r_in_hold <= 1'b1;
          end else if (r_sign != r_dir) begin
            r_state    <= DIR_WAIT;
            r_dir_done <= 1'b0;
          end
        end
        DIR_WAIT: begin
          // Direction only flips once the pin is low, so an in-flight pulse keeps its old dir.
          if (!r_dir_done) begin
            if (!w_step) begin
              r_dir       <= ~r_dir;
              r_dir_done  <= 1'b1;
              r_setup_cnt <= c_SETUP_LOAD;
            end
          end else if (r_setup_cnt != '0) begin
            r_setup_cnt <= r_setup_cnt - c_ONE;
          end else begin
            r_state <= TRACK;
          end
        end
        default: r_state <= OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
    end else if (w_start) begin
      r_step_cnt <= r_dir ? (r_step_cnt - c_ONE) : (r_step_cnt + c_ONE);
    end
  end

  assign bus.drv_step = w_step;
  assign bus.drv_dir  = r_dir;
  assign bus.drv_SM   = r_sm;
  assign step_cnt     = r_step_cnt;
  assign zone         = r_zone;
  assign in_hold      = r_in_hold;

endmodule
`default_nettype wire

// File: tb/tb_tr_step_regulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tr_step_regulator : directed self-checking bench for tr_step_regulator
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tr_step_regulator;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic enable   = 1'b0;
  logic enable_w = 1'b0;
  always #10 clk = ~clk;

  tr_step_regulator_if #(.WIDTH_IN(12)) bus ();
  tr_step_regulator_if #(.WIDTH_IN(12)) bus_w ();

  logic [16:0] step_cnt;
  logic [1:0]  zone;
  logic        in_hold;
  logic [7:0]  step_cnt_w;
  logic [1:0]  zone_w;
  logic        in_hold_w;

  // Mid/fine periods shortened so the whole zone descent fits a short run.
  tr_step_regulator #(.P_MID(3960), .P_FINE(8000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .step_cnt(step_cnt), .zone(zone), .in_hold(in_hold)
  );

  tr_step_regulator #(
    .WIDTH_WORK(8), .PULSE_W(2), .DIR_SETUP(3),
    .P_COARSE(4), .P_MID(100), .P_FINE(200)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(enable_w), .bus(bus_w),
    .step_cnt(step_cnt_w), .zone(zone_w), .in_hold(in_hold_w)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rise = 0, last_rise = 0, prev_rise = 0, last_width = 0, dir_cyc = 0;
  int n_rise_w = 0;
  logic prev_step = 1'b0, prev_dir = 1'b0, prev_step_w = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.drv_step === 1'b1 && prev_step === 1'b0) begin
      prev_rise = last_rise;
      last_rise = cyc;
      n_rise++;
    end
    if (bus.drv_step === 1'b0 && prev_step === 1'b1) last_width = cyc - last_rise;
    if (bus.drv_dir !== prev_dir) dir_cyc = cyc;
    if (bus_w.drv_step === 1'b1 && prev_step_w === 1'b0) n_rise_w++;
    prev_step   = bus.drv_step;
    prev_dir    = bus.drv_dir;
    prev_step_w = bus_w.drv_step;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply(input int xv, input int x0v, input int d1, input int d2);
    bus.x = 12'(xv); bus.x0 = 12'(x0v); bus.dx1 = 12'(d1); bus.dx2 = 12'(d2);
    bus.data_valid = 1'b1;
    tick(1);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    int goal = n_rise + n;
    int k = 0;
    while (n_rise < goal && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (n_rise < goal) begin
      errors++;
      $display("FAIL %s: timeout, saw %0d pulses, required %0d", name, n_rise, goal);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.drv_step !== 1'b0) begin errors++; $display("FAIL rst_step: got %b, expected 0", bus.drv_step); end
    checks++; if (bus.drv_dir !== 1'b0) begin errors++; $display("FAIL rst_dir: got %b, expected 0", bus.drv_dir); end
    checks++; if (bus.drv_SM !== 1'b0) begin errors++; $display("FAIL rst_sm: got %b, expected 0", bus.drv_SM); end
    checks++; if (step_cnt !== 17'd0) begin errors++; $display("FAIL rst_cnt: got %0d, expected 0", step_cnt); end
    checks++; if (zone !== 2'd0) begin errors++; $display("FAIL rst_zone: got %0d, expected 0", zone); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b, expected 0", in_hold); end
    tick(2);
    rst_n = 1'b1;
    apply(1500, 1000, 10, 100);
    tick(100);
    checks++; if (bus.drv_SM !== 1'b0) begin errors++; $display("FAIL off_sm: got %b, expected 0", bus.drv_SM); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL off_hold: got %b, expected 0", in_hold); end
    checks++; if (n_rise != 0) begin errors++; $display("FAIL off_pulses: got %0d, expected 0", n_rise); end
    checks++; if (zone !== 2'd3) begin errors++; $display("FAIL off_zone: got %0d, expected 3", zone); end
  endtask

  task automatic test_coarse();
    int t0 = cyc;
    enable = 1'b1;
    wait_rises(1, 10, "coarse_first");
    checks++; if (last_rise - t0 != 2) begin errors++; $display("FAIL coarse_latency: got %0d, expected 2", last_rise - t0); end
    checks++; if (bus.drv_dir !== 1'b0) begin errors++; $display("FAIL coarse_dir: got %b, expected 0", bus.drv_dir); end
    checks++; if (bus.drv_SM !== 1'b1) begin errors++; $display("FAIL coarse_sm: got %b, expected 1", bus.drv_SM); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL coarse_hold: got %b, expected 0", in_hold); end
    wait_rises(3, 3000, "coarse_run");
    tick(55);
    checks++; if (step_cnt !== 17'd4) begin errors++; $display("FAIL coarse_cnt: got %0d, expected 4", step_cnt); end
    checks++; if (last_width != 50) begin errors++; $display("FAIL coarse_width: got %0d, expected 50", last_width); end
    checks++; if (last_rise - prev_rise != 800) begin errors++; $display("FAIL coarse_period: got %0d, expected 800", last_rise - prev_rise); end
    checks++; if (zone !== 2'd3) begin errors++; $display("FAIL coarse_zone: got %0d, expected 3", zone); end
  endtask

  task automatic test_zone_descent();
    int n0;
    apply(1050, 1000, 10, 100);
    tick(3);
    checks++; if (zone !== 2'd2) begin errors++; $display("FAIL mid_zone: got %0d, expected 2", zone); end
    wait_rises(1, 1000, "mid_first");
    checks++; if (last_rise - prev_rise != 800) begin errors++; $display("FAIL mid_latched: got %0d, expected 800", last_rise - prev_rise); end
    wait_rises(1, 5000, "mid_second");
    checks++; if (last_rise - prev_rise != 3960) begin errors++; $display("FAIL mid_period: got %0d, expected 3960", last_rise - prev_rise); end
    tick(55);
    apply(1005, 1000, 10, 100);
    tick(3);
    checks++; if (zone !== 2'd1) begin errors++; $display("FAIL fine_zone: got %0d, expected 1", zone); end
    wait_rises(1, 5000, "fine_first");
    checks++; if (last_rise - prev_rise != 3960) begin errors++; $display("FAIL fine_latched: got %0d, expected 3960", last_rise - prev_rise); end
    wait_rises(1, 9000, "fine_second");
    checks++; if (last_rise - prev_rise != 8000) begin errors++; $display("FAIL fine_period: got %0d, expected 8000", last_rise - prev_rise); end
    tick(55);
    checks++; if (step_cnt !== 17'd8) begin errors++; $display("FAIL fine_cnt: got %0d, expected 8", step_cnt); end
    apply(1000, 1000, 10, 100);
    tick(3);
    checks++; if (in_hold !== 1'b1) begin errors++; $display("FAIL hold_enter: got %b, expected 1", in_hold); end
    checks++; if (zone !== 2'd0) begin errors++; $display("FAIL hold_zone: got %0d, expected 0", zone); end
    n0 = n_rise;
    tick(8100);
    checks++; if (n_rise != n0) begin errors++; $display("FAIL hold_pulses: got %0d, expected %0d", n_rise, n0); end
    checks++; if (bus.drv_SM !== 1'b1) begin errors++; $display("FAIL hold_sm: got %b, expected 1", bus.drv_SM); end
  endtask

  task automatic test_hysteresis();
    int n0 = n_rise;
    int d;
    apply(1019, 1000, 10, 100);
    tick(30);
    checks++; if (in_hold !== 1'b1) begin errors++; $display("FAIL dz19_hold: got %b, expected 1", in_hold); end
    checks++; if (n_rise != n0) begin errors++; $display("FAIL dz19_pulses: got %0d, expected %0d", n_rise, n0); end
    d = cyc;
    apply(1020, 1000, 10, 100);
    wait_rises(1, 10, "dz20_track");
    checks++; if (last_rise - d != 3) begin errors++; $display("FAIL dz20_latency: got %0d, expected 3", last_rise - d); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL dz20_hold: got %b, expected 0", in_hold); end
  endtask

  task automatic test_reversal();
    apply(400, 1000, 10, 100);
    wait_rises(1, 1000, "rev_pulse");
    checks++; if (last_width != 50) begin errors++; $display("FAIL rev_width: got %0d, expected 50", last_width); end
    checks++; if (dir_cyc < prev_rise + 50) begin errors++; $display("FAIL rev_toggle_early: got cycle %0d, expected >= %0d", dir_cyc, prev_rise + 50); end
    checks++; if (last_rise - dir_cyc != 250) begin errors++; $display("FAIL rev_setup: got %0d, expected 250", last_rise - dir_cyc); end
    checks++; if (bus.drv_dir !== 1'b1) begin errors++; $display("FAIL rev_dir: got %b, expected 1", bus.drv_dir); end
    tick(55);
    checks++; if (step_cnt !== 17'd8) begin errors++; $display("FAIL rev_cnt: got %0d, expected 8", step_cnt); end
    checks++; if (zone !== 2'd3) begin errors++; $display("FAIL rev_zone: got %0d, expected 3", zone); end
  endtask

  task automatic test_disable_mid_pulse();
    int n1;
    wait_rises(1, 1000, "dis_pulse");
    tick(5);
    enable = 1'b0;
    tick(1);
    checks++; if (bus.drv_SM !== 1'b0) begin errors++; $display("FAIL dis_sm: got %b, expected 0", bus.drv_SM); end
    checks++; if (bus.drv_step !== 1'b1) begin errors++; $display("FAIL dis_step_kept: got %b, expected 1", bus.drv_step); end
    tick(60);
    checks++; if (last_width != 50) begin errors++; $display("FAIL dis_width: got %0d, expected 50", last_width); end
    n1 = n_rise;
    tick(1000);
    checks++; if (n_rise != n1) begin errors++; $display("FAIL dis_pulses: got %0d, expected %0d", n_rise, n1); end
    checks++; if (step_cnt !== 17'd7) begin errors++; $display("FAIL dis_cnt: got %0d, expected 7", step_cnt); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL dis_hold: got %b, expected 0", in_hold); end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    wait_rises(1, 10, "arst_pulse");
    checks++; if (bus.drv_dir !== 1'b1) begin errors++; $display("FAIL arst_pre_dir: got %b, expected 1", bus.drv_dir); end
    tick(10);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.drv_step !== 1'b0) begin errors++; $display("FAIL arst_step: got %b, expected 0", bus.drv_step); end
    checks++; if (bus.drv_dir !== 1'b0) begin errors++; $display("FAIL arst_dir: got %b, expected 0", bus.drv_dir); end
    checks++; if (bus.drv_SM !== 1'b0) begin errors++; $display("FAIL arst_sm: got %b, expected 0", bus.drv_SM); end
    checks++; if (step_cnt !== 17'd0) begin errors++; $display("FAIL arst_cnt: got %0d, expected 0", step_cnt); end
    checks++; if (zone !== 2'd0) begin errors++; $display("FAIL arst_zone: got %0d, expected 0", zone); end
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL arst_hold: got %b, expected 0", in_hold); end
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_wrap();
    int k = 0;
    bus_w.x = 12'd1500; bus_w.x0 = 12'd1000; bus_w.dx1 = 12'd10; bus_w.dx2 = 12'd100;
    bus_w.data_valid = 1'b1;
    tick(1);
    bus_w.data_valid = 1'b0;
    tick(2);
    enable_w = 1'b1;
    while (n_rise_w < 127 && k < 1000) begin tick(1); k++; end
    tick(2);
    checks++; if (step_cnt_w !== 8'h7F) begin errors++; $display("FAIL wrap_max: got %0d, expected 127", step_cnt_w); end
    k = 0;
    while (n_rise_w < 128 && k < 100) begin tick(1); k++; end
    tick(2);
    checks++; if (step_cnt_w !== 8'h80) begin errors++; $display("FAIL wrap_min: got 0x%0h, expected 0x80", step_cnt_w); end
    enable_w = 1'b0;
  endtask

  initial begin
    bus.data_valid = 1'b0; bus.x = '0; bus.x0 = '0; bus.dx1 = '0; bus.dx2 = '0;
    bus_w.data_valid = 1'b0; bus_w.x = '0; bus_w.x0 = '0; bus_w.dx1 = '0; bus_w.dx2 = '0;
    test_reset();
    test_coarse();
    test_zone_descent();
    test_hysteresis();
    test_reversal();
    test_disable_mid_pulse();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
